// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 asynchronous serial receiver.
// It synchronises rx, finds the start edge and samples each bit at its centre.
// Each good byte is presented on a valid/ready output register.
// It also flags false starts (silently dropped), framing errors and overruns.
module uart_rx_byte #(
    parameter int unsigned CLKS_PER_BIT = 868,  // legal range: 4 or more
    parameter int unsigned DATA_BITS    = 8     // only 8 is supported
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned HalfBit = CLKS_PER_BIT / 2;
    localparam int unsigned CntW    = $clog2(CLKS_PER_BIT);
    localparam int unsigned BitW    = $clog2(DATA_BITS);

    // Terminal counts: the cycle counter clears on entry to each state, so the
    // sample point of a state is reached when the counter equals (period - 1).
    localparam logic [CntW-1:0] HalfLast = CntW'(HalfBit - 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [BitW-1:0] LastBit  = BitW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    // ------------------------------------------------------------------
    // Input synchroniser and start-edge qualification
    // ------------------------------------------------------------------
    logic [1:0] sync_q;      // [0] first stage, [1] synchronised line
    logic       rx_s;
    logic       rx_prev_q;
    logic [1:0] fill_q;      // marks when sync_q[1] holds a real line sample
    logic       armed_q;     // line has been seen high since reset
    logic       armed_d;
    logic       start_edge;

    assign rx_s = sync_q[1];

    // The synchroniser resets to 1, so right after reset it reports an idle
    // line that may not exist. Arm edge detection only after a genuine high
    // sample, so a reset in the middle of a low bit cannot fake a start.
    assign armed_d    = armed_q | (fill_q[1] & rx_s);
    assign start_edge = armed_q & rx_prev_q & ~rx_s;

    // Synchroniser, edge-detect history and arming flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
            fill_q    <= 2'b00;
            armed_q   <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], rx};
            rx_prev_q <= rx_s;
            fill_q    <= {fill_q[0], 1'b1};
            armed_q   <= armed_d;
        end
    end

    // ------------------------------------------------------------------
    // Receive state machine
    // ------------------------------------------------------------------
    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [BitW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   deliver;     // stop bit good: hand the byte over
    logic                   stop_bad;    // stop bit sampled low

    // FSM state, cycle counter, bit counter and shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // Next-state logic: sample at mid-start, then at each data bit centre and the stop centre.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        deliver  = 1'b0;
        stop_bad = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                bit_d = '0;
                if (start_edge) begin
                    state_d = StStart;
                end
            end

            StStart: begin
                if (cnt_q == HalfLast) begin
                    cnt_d = '0;
                    // A line back high at mid-start was a glitch: drop it quietly.
                    state_d = rx_s ? StIdle : StData;
                end
            end

            StData: begin
                if (cnt_q == BitLast) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};  // LSB arrives first
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == LastBit) begin
                        state_d = StStop;
                    end
                end
            end

            StStop: begin
                if (cnt_q == BitLast) begin
                    cnt_d    = '0;
                    state_d  = StIdle;
                    deliver  = rx_s;
                    stop_bad = ~rx_s;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output register and valid/ready handshake
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] out_q, out_d;
    logic                 out_valid_q, out_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;

    // Handshake next-state: a delivery wins over a consume on the same cycle.
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        overrun_d   = 1'b0;
        frame_err_d = stop_bad;

        if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (deliver) begin
            out_d       = shift_q;
            out_valid_d = 1'b1;
            // Only a byte nobody is taking this cycle counts as lost.
            overrun_d   = out_valid_q & ~out_ready;
        end
    end

    // Output registers; the error flags are single-cycle pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte. A cycle-indexed plan of line activity is built up front from frame
// timing arithmetic (start edge seen two cycles after the line drops, byte due half a bit plus
// nine bits later). The plan is then replayed while outputs are compared every cycle.
module tb_uart_rx_byte;

    localparam int C     = 8;
    localparam int H     = C / 2;
    localparam int FRAME = 10 * C;
    // From the cycle the start bit is driven to the cycle the result is visible.
    localparam int DEL   = 3 + H + 9 * C;
    localparam int NCYC  = 5000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic       out_ready = 1'b0;
    logic [7:0] out;
    logic       out_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx_byte #(
        .CLKS_PER_BIT(C),
        .DATA_BITS   (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .out      (out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Plan, indexed by negedge iteration.
    bit       rx_plan   [NCYC];
    bit       rdy_plan  [NCYC];
    bit       rst_plan  [NCYC];
    bit       del_plan  [NCYC];
    bit [7:0] del_byte  [NCYC];
    bit       ferr_plan [NCYC];
    bit       busy_exp  [NCYC];
    bit       dont_care [NCYC];

    int       n_checks = 0;
    int       n_errors = 0;
    int       cur = -1;

    bit       m_valid;
    bit [7:0] m_out;
    bit       e_ovr;
    bit       rdy_prev;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cur, got, exp);
        end
    endtask

    task automatic check_reset_values(input string when);
        check_eq({when, " out"},       32'(out),       32'(0));
        check_eq({when, " out_valid"}, 32'(out_valid), 32'(0));
        check_eq({when, " frame_err"}, 32'(frame_err), 32'(0));
        check_eq({when, " overrun"},   32'(overrun),   32'(0));
        check_eq({when, " busy"},      32'(busy),      32'(0));
    endtask

    // One 8N1 frame starting at iteration n; when modelled, its outcome is scheduled.
    task automatic plan_frame(input int n, input bit [7:0] b, input bit stop, input bit modelled);
        for (int i = 0; i < 10; i++) begin
            bit v;
            if (i == 0) v = 1'b0;
            else if (i == 9) v = stop;
            else v = b[i-1];
            for (int j = 0; j < C; j++) rx_plan[n + i*C + j] = v;
        end
        if (modelled) begin
            for (int k = n + 3; k < n + DEL; k++) busy_exp[k] = 1'b1;
            if (stop) begin
                del_plan[n + DEL] = 1'b1;
                del_byte[n + DEL] = b;
            end else begin
                ferr_plan[n + DEL] = 1'b1;
            end
        end
    endtask

    // Low pulse shorter than half a bit: receiver wakes up, then gives up at mid-start.
    task automatic plan_glitch(input int n, input int len);
        for (int j = 0; j < len; j++) rx_plan[n + j] = 1'b0;
        for (int k = n + 3; k <= n + 2 + H; k++) busy_exp[k] = 1'b1;
    endtask

    task automatic set_ready(input int from, input int upto, input bit v);
        for (int k = from; k < upto; k++) rdy_plan[k] = v;
    endtask

    task automatic build_plan();
        int n;
        for (int c = 0; c < NCYC; c++) begin
            rx_plan[c] = 1'b1;
            rdy_plan[c] = 1'b0;
            rst_plan[c] = 1'b0;
            del_plan[c] = 1'b0;
            del_byte[c] = 8'h00;
            ferr_plan[c] = 1'b0;
            busy_exp[c] = 1'b0;
            dont_care[c] = 1'b0;
        end
        for (int c = 0; c < 4; c++) rst_plan[c] = 1'b1;

        // 'a' with the consumer always ready.
        plan_frame(20, 8'h61, 1'b1, 1'b1);
        set_ready(20, 310, 1'b1);
        // Two-cycle glitch.
        plan_glitch(120, 2);
        // Bad stop bit, then a clean frame once the line is back high.
        plan_frame(140, 8'h5A, 1'b0, 1'b1);
        plan_frame(222, 8'h41, 1'b1, 1'b1);
        // Back-to-back with nobody reading: overrun, then a one-cycle consume.
        plan_frame(320, 8'h48, 1'b1, 1'b1);
        plan_frame(400, 8'h7A, 1'b1, 1'b1);
        rdy_plan[485] = 1'b1;
        // Consume coinciding with the second delivery: no overrun.
        plan_frame(500, 8'h48, 1'b1, 1'b1);
        plan_frame(580, 8'h7A, 1'b1, 1'b1);
        rdy_plan[658] = 1'b1;
        // Reset 30 cycles after the start edge; the rest of the frame must not deliver.
        plan_frame(700, 8'h00, 1'b1, 1'b0);
        for (int k = 703; k <= 732; k++) busy_exp[k] = 1'b1;
        for (int k = 732; k < 735; k++) rst_plan[k] = 1'b1;
        for (int k = 735; k < 900; k++) dont_care[k] = 1'b1;
        plan_frame(900, 8'h30, 1'b1, 1'b1);
        set_ready(990, 1000, 1'b1);

        // Random traffic: good frames, framing errors and glitches with random gaps.
        n = 1010;
        while (n + FRAME + 30 < NCYC) begin
            int unsigned k;
            k = $urandom_range(0, 9);
            if (k < 7) begin
                plan_frame(n, 8'($urandom), 1'b1, 1'b1);
                n += FRAME + int'($urandom_range(0, 10));
            end else if (k == 7) begin
                plan_frame(n, 8'($urandom), 1'b0, 1'b1);
                n += FRAME + 2 + int'($urandom_range(0, 10));
            end else begin
                plan_glitch(n, int'($urandom_range(1, H - 1)));
                n += H + 1 + int'($urandom_range(0, 8));
            end
        end
        for (int b = 1010; b < NCYC; b += 150) begin
            int unsigned mode;
            mode = $urandom_range(0, 2);
            for (int j = b; j < b + 150 && j < NCYC; j++) begin
                if (mode == 0) rdy_plan[j] = 1'b0;
                else if (mode == 1) rdy_plan[j] = 1'b1;
                else rdy_plan[j] = 1'($urandom_range(0, 1));
            end
        end
    endtask

    initial begin
        build_plan();
        #1 rst = 1'b1;
        #1 check_reset_values("por");
        m_valid  = 1'b0;
        m_out    = 8'h00;
        rdy_prev = 1'b0;

        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            cur = c;
            e_ovr = 1'b0;
            if (rst) begin
                m_valid = 1'b0;
                m_out   = 8'h00;
            end else if (del_plan[c]) begin
                e_ovr   = m_valid && !rdy_prev;
                m_out   = del_byte[c];
                m_valid = 1'b1;
            end else if (rdy_prev) begin
                m_valid = 1'b0;
            end

            check_eq("out_valid", 32'(out_valid), 32'(m_valid));
            check_eq("out",       32'(out),       32'(m_out));
            check_eq("overrun",   32'(overrun),   32'(e_ovr));
            if (!dont_care[c]) begin
                check_eq("frame_err", 32'(frame_err), 32'(ferr_plan[c]));
                check_eq("busy",      32'(busy),      32'(busy_exp[c]));
            end

            rx        = rx_plan[c];
            out_ready = rdy_plan[c];
            rdy_prev  = rdy_plan[c];
            if (rst_plan[c] && !rst) begin
                rst = 1'b1;
                #1;
                m_valid = 1'b0;
                m_out   = 8'h00;
                check_reset_values("async_rst");
            end else if (!rst_plan[c]) begin
                rst = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
